tt_swap_arb: RTL and testbench

TT_SWAP_ARB -- requirements
Module: tt_swap_arb

---
 rtl/tt_swap_arb.sv | 139 +++++++++++++
 tb/tb_tt_swap_arb.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/tt_swap_arb.sv
// tt_swap_arb
// Arbiter for a 2x2 swap element fed by two sources. Each arbitration picks
// the swap key and the grants, then holds them for a burst of BURST_LEN
// cycles. Two sources may share a burst only when their destinations differ.
// When both sources want the same output, a round-robin pointer picks the
// winner, and the loser gets priority at the next contended arbitration.
//
// Ports
//   clk      : single clock; all state changes on the rising edge
//   rst      : asynchronous active-high reset
//   req0     : source 0 (swap input a) requests the switch
//   dst0     : source 0 destination (0 = output c, 1 = output d)
//   req1     : source 1 (swap input b) requests the switch
//   dst1     : source 1 destination (0 = output c, 1 = output d)
//   key      : swap control (0 = a->c, b->d; 1 = b->c, a->d)
//   gnt0     : source 0 granted
//   gnt1     : source 1 granted
//   busy     : a burst is in progress
//   conflict : one-cycle pulse after a contended arbitration
module tt_swap_arb #(
    parameter int unsigned BURST_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic dst0,
    input  logic req1,
    input  logic dst1,
    output logic key,
    output logic gnt0,
    output logic gnt1,
    output logic busy,
    output logic conflict
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(BURST_LEN - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rr_q, rr_d;
    logic       key_q, key_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic       busy_q, busy_d;
    logic       conflict_q, conflict_d;
    logic       arb;

    // Next-state logic. In IDLE the grants stay cleared and the key keeps
    // its last value. While a burst is running, a grant can only drop out;
    // new requests wait until the counter reaches zero.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        key_d      = key_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        conflict_d = 1'b0;

        arb = (req0 | req1) & ((state_q == IDLE) | (cnt_q == 4'd0));

        if (arb) begin
            state_d = HOLD;
            cnt_d   = CNT_LOAD;
            if (req0 && !req1) begin
                gnt0_d = 1'b1;
                key_d  = dst0;
            end else if (!req0 && req1) begin
                gnt1_d = 1'b1;
                key_d  = ~dst1;
            end else if (dst0 != dst1) begin
                // Different outputs: one key value serves both sources.
                gnt0_d = 1'b1;
                gnt1_d = 1'b1;
                key_d  = dst0;
            end else begin
                // Same output: the pointer picks the winner, then points at the loser.
                conflict_d = 1'b1;
                if (!rr_q) begin
                    gnt0_d = 1'b1;
                    key_d  = dst0;
                    rr_d   = 1'b1;
                end else begin
                    gnt1_d = 1'b1;
                    key_d  = ~dst1;
                    rr_d   = 1'b0;
                end
            end
        end else if (state_q == HOLD && cnt_q != 4'd0) begin
            gnt0_d = gnt0_q & req0;
            gnt1_d = gnt1_q & req1;
            cnt_d  = 4'(cnt_q - 4'd1);
            // If both granted sources have dropped their requests, end the burst early.
            if (!gnt0_d && !gnt1_d) begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        end else begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end

        busy_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            rr_q       <= 1'b0;
            key_q      <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            key_q      <= key_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    assign key      = key_q;
    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign busy     = busy_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_tt_swap_arb.sv
// tb_tt_swap_arb
// Directed bench for tt_swap_arb. It builds two instances, one with a burst
// length of 4 and one with a burst length of 1. Both instances share the
// same inputs.
//
// For each cycle, the stimulus task pushes the expected outputs
// {key, gnt0, gnt1, busy, conflict} for the following cycle, tagged with the
// instance that should be checked. A monitor samples shortly after each
// rising edge. It pops the next expectation and compares it with the outputs
// of that instance.
module tb_tt_swap_arb;

    logic clk;
    logic rst;
    logic req0, dst0, req1, dst1;
    logic key_a, gnt0_a, gnt1_a, busy_a, conflict_a;
    logic key_b, gnt0_b, gnt1_b, busy_b, conflict_b;

    typedef struct {
        logic       sel;
        logic [4:0] exp;
        int         id;
    } exp_t;

    exp_t exp_q[$];
    int   compared;
    int   mismatched;
    int   vec_id;

    tt_swap_arb #(.BURST_LEN(4)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .dst0     (dst0),
        .req1     (req1),
        .dst1     (dst1),
        .key      (key_a),
        .gnt0     (gnt0_a),
        .gnt1     (gnt1_a),
        .busy     (busy_a),
        .conflict (conflict_a)
    );

    tt_swap_arb #(.BURST_LEN(1)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .dst0     (dst0),
        .req1     (req1),
        .dst1     (dst1),
        .key      (key_b),
        .gnt0     (gnt0_b),
        .gnt1     (gnt1_b),
        .busy     (busy_b),
        .conflict (conflict_b)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compares one output bundle {key, gnt0, gnt1, busy, conflict} against the expected value.
    task automatic checkOutput(input string name, input logic [4:0] got, input logic [4:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: key/gnt0/gnt1/busy/conflict got %b required %b", name, got, exp);
        end
    endtask

    // Drives one cycle of inputs at the falling edge and queues the outputs
    // expected after the next rising edge.
    task automatic applyStimulus(input logic r0, input logic d0, input logic r1, input logic d1,
                                 input logic sel, input logic [4:0] exp);
        exp_t e;
        @(negedge clk);
        req0 = r0;
        dst0 = d0;
        req1 = r1;
        dst1 = d1;
        vec_id++;
        e.sel = sel;
        e.exp = exp;
        e.id  = vec_id;
        exp_q.push_back(e);
    endtask

    // Monitor: samples 2 units after each rising edge and checks the next queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.sel)
                checkOutput($sformatf("vec%0d_b1", e.id), {key_b, gnt0_b, gnt1_b, busy_b, conflict_b}, e.exp);
            else
                checkOutput($sformatf("vec%0d_b4", e.id), {key_a, gnt0_a, gnt1_a, busy_a, conflict_a}, e.exp);
        end
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        vec_id     = 0;
        rst  = 1'b1;
        req0 = 1'b0;
        dst0 = 1'b0;
        req1 = 1'b0;
        dst1 = 1'b0;
        #1;
        checkOutput("reset_b4", {key_a, gnt0_a, gnt1_a, busy_a, conflict_a}, 5'b00000);
        checkOutput("reset_b1", {key_b, gnt0_b, gnt1_b, busy_b, conflict_b}, 5'b00000);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single request to output d: burst of 4, then back-to-back re-grant.
        applyStimulus(1, 1, 0, 0, 0, 5'b11010);
        applyStimulus(1, 1, 0, 0, 0, 5'b11010);
        applyStimulus(1, 1, 0, 0, 0, 5'b11010);
        applyStimulus(1, 1, 0, 0, 0, 5'b11010);
        applyStimulus(1, 1, 0, 0, 0, 5'b11010);
        // Early end when the only granted source drops its request; key holds 1.
        applyStimulus(0, 1, 0, 0, 0, 5'b10000);
        applyStimulus(0, 0, 0, 0, 0, 5'b10000);
        // Both sources, different outputs: both granted, key = dst0; dst changes are ignored mid-burst.
        applyStimulus(1, 0, 1, 1, 0, 5'b01110);
        applyStimulus(1, 1, 1, 1, 0, 5'b01110);
        applyStimulus(0, 0, 0, 0, 0, 5'b00000);
        // Contention on output c: source 0 wins first, then source 1, then source 0 again.
        applyStimulus(1, 0, 1, 0, 0, 5'b01011);
        applyStimulus(1, 0, 1, 0, 0, 5'b01010);
        applyStimulus(1, 0, 1, 0, 0, 5'b01010);
        applyStimulus(1, 0, 1, 0, 0, 5'b01010);
        applyStimulus(1, 0, 1, 0, 0, 5'b10111);
        applyStimulus(1, 0, 1, 0, 0, 5'b10110);
        applyStimulus(1, 0, 1, 0, 0, 5'b10110);
        applyStimulus(1, 0, 1, 0, 0, 5'b10110);
        applyStimulus(1, 0, 1, 0, 0, 5'b01011);
        // The losing source drops and then re-raises its request; it is not added mid-burst.
        applyStimulus(1, 0, 0, 0, 0, 5'b01010);
        applyStimulus(1, 0, 1, 0, 0, 5'b01010);
        applyStimulus(1, 0, 1, 0, 0, 5'b01010);
        applyStimulus(1, 0, 1, 0, 0, 5'b10111);
        applyStimulus(0, 0, 0, 0, 0, 5'b10000);
        // Source 0 drops its request in the second burst cycle.
        applyStimulus(1, 0, 0, 0, 0, 5'b01010);
        applyStimulus(1, 0, 0, 0, 0, 5'b01010);
        applyStimulus(0, 0, 0, 0, 0, 5'b00000);
        // Contention on output d leaves the pointer at source 1; then reset mid-burst.
        applyStimulus(1, 1, 1, 1, 0, 5'b11011);
        applyStimulus(1, 1, 1, 1, 0, 5'b11010);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_b4", {key_a, gnt0_a, gnt1_a, busy_a, conflict_a}, 5'b00000);
        checkOutput("async_rst_b1", {key_b, gnt0_b, gnt1_b, busy_b, conflict_b}, 5'b00000);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        // After reset, source 0 wins the first contention.
        applyStimulus(1, 1, 1, 1, 0, 5'b11011);
        applyStimulus(0, 0, 0, 0, 1, 5'b10000);
        // Burst length 1: contending sources alternate every cycle, with conflict high each cycle.
        applyStimulus(1, 1, 1, 1, 1, 5'b00111);
        applyStimulus(1, 1, 1, 1, 1, 5'b11011);
        applyStimulus(1, 1, 1, 1, 1, 5'b00111);
        applyStimulus(1, 1, 1, 1, 1, 5'b11011);
        applyStimulus(0, 0, 0, 0, 1, 5'b10000);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
